mem_arbiter: RTL

Two-port arbiter that shares the CPU's single-port 16-bit data memory between the CPU data path (port 0) and a loader/debug master (port 1). It accepts one request per port with a req/gnt handshake, runs round-robin arbitration with an optional bounded lock for bursts, and drives the memory command for one cycle per transaction. It returns per-port read data with a fixed latency.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port data memory between the CPU data path (port 0)
// and a loader/debug master (port 1). Round-robin arbitration with a bounded lock,
// one memory command per transaction, read data returned two cycles after the request.
module mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (MAX_LOCK < 1) ? 1 : $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic              lock_vld_q, lock_vld_d;
    logic              lock_own_q, lock_own_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] lck;
    logic       own_req;
    logic       lock_expired;
    logic       lock_win;
    logic       winner;

    assign req = {m1_req, m0_req};
    assign we  = {m1_we, m0_we};
    assign lck = {m1_lock, m0_lock};

    // The lock holder keeps priority only while it is requesting and still under its
    // grant budget; otherwise the round-robin pointer decides.
    assign own_req      = req[lock_own_q];
    assign lock_expired = lock_vld_q && (lock_cnt_q >= CNT_MAX);
    assign lock_win     = lock_vld_q && own_req && !lock_expired;
    assign winner       = lock_win ? lock_own_q : (req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q);

    // Next-state logic: arbitrate in IDLE, drive the command for exactly one ISSUE cycle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_vld_d  = lock_vld_q;
        lock_own_d  = lock_own_q;
        lock_cnt_d  = lock_cnt_q;
        gnt_d       = 2'b00;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // a read issued this cycle returns its data in the following cycle
        rvalid_d    = gnt_q & {2{mem_re_q}};
        // the memory output is itself registered; it is only captured for holding
        rdata0_d    = rvalid_q[0] ? mem_rdata : rdata0_q;
        rdata1_d    = rvalid_q[1] ? mem_rdata : rdata1_q;

        case (state_q)
            S_IDLE: begin
                // an owner that stops requesting gives up the lock at once
                if (lock_vld_q && !own_req) begin
                    lock_vld_d = 1'b0;
                    lock_cnt_d = '0;
                end
                if (|req) begin
                    state_d        = S_ISSUE;
                    gnt_d[winner]  = 1'b1;
                    mem_we_d       = we[winner];
                    mem_re_d       = ~we[winner];
                    mem_addr_d     = winner ? m1_addr : m0_addr;
                    mem_wdata_d    = winner ? m1_wdata : m0_wdata;
                    rr_ptr_d       = ~winner;
                    if (lck[winner]) begin
                        lock_vld_d = 1'b1;
                        lock_own_d = winner;
                        // continuing a live lock extends the run; anything else starts fresh
                        lock_cnt_d = lock_win ? (lock_cnt_q + CNT_W'(1)) : CNT_W'(1);
                    end else begin
                        lock_vld_d = 1'b0;
                        lock_cnt_d = '0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset also clears the pending read so no rvalid follows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= 1'b0;
            lock_vld_q  <= 1'b0;
            lock_own_q  <= 1'b0;
            lock_cnt_q  <= '0;
            gnt_q       <= 2'b00;
            rvalid_q    <= 2'b00;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_vld_q  <= lock_vld_d;
            lock_own_q  <= lock_own_d;
            lock_cnt_q  <= lock_cnt_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign m0_gnt    = gnt_q[0];
    assign m1_gnt    = gnt_q[1];
    assign m0_rvalid = rvalid_q[0];
    assign m1_rvalid = rvalid_q[1];
    assign m0_rdata  = rvalid_q[0] ? mem_rdata : rdata0_q;
    assign m1_rdata  = rvalid_q[1] ? mem_rdata : rdata1_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
